// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
//
// Hazard and stall controller for the 5-stage MIPS pipeline with an L1 data
// cache. Forwarding handles the hazards that can be bypassed. This block
// handles the three cases that need the pipeline to stall or flush:
//   - load-use bubbles,
//   - a full-pipeline freeze while the D-cache services a miss,
//   - IF/ID flushes on taken branches.
// A branch that resolves during a freeze is latched in flushPendingReg. Its
// flush is applied on the first non-stalled cycle that has no load-use hazard.
//
// Optional feature macro: HAZARD_PERF_CNT_EN. When it is defined, the block
// adds the CNT_W parameter, the saturating counters and the two counter ports.
//
// Ports:
//   clk_i             in   pipeline clock, rising edge
//   rst_i             in   asynchronous active-high reset
//   ID_EX_MemRead     in   instruction in EX is a load
//   ID_EX_RegisterRt  in   [4:0] load destination register
//   IF_ID_RegisterRs  in   [4:0] rs of the instruction in ID
//   IF_ID_RegisterRt  in   [4:0] rt of the instruction in ID
//   branch_taken_i    in   branch in ID resolved taken this cycle
//   dcache_stall_i    in   D-cache miss in progress (level)
//   pc_write_o        out  PC write enable
//   if_id_write_o     out  IF/ID write enable
//   id_ex_bubble_o    out  zero the ID/EX control fields
//   if_id_flush_o     out  squash the IF/ID instruction
//   pipe_freeze_o     out  hold ID/EX, EX/MEM and MEM/WB
//   state_o           out  [1:0] FSM state (RUN=00, MISS=01)
//   loaduse_cnt_o     out  [CNT_W-1:0] bubbles inserted (macro only)
//   miss_cnt_o        out  [CNT_W-1:0] miss episodes (macro only)
// -----------------------------------------------------------------------------
module hazard_stall_unit
`ifdef HAZARD_PERF_CNT_EN
#(
  parameter int CNT_W = 16
)
`endif
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_RegisterRt,
  input  logic [4:0] IF_ID_RegisterRs,
  input  logic [4:0] IF_ID_RegisterRt,
  input  logic       branch_taken_i,
  input  logic       dcache_stall_i,
  output logic       pc_write_o,
  output logic       if_id_write_o,
  output logic       id_ex_bubble_o,
  output logic       if_id_flush_o,
  output logic       pipe_freeze_o,
  output logic [1:0] state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] loaduse_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
`endif
);

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    MISS = 2'b01
  } stateT;

  stateT stateReg, stateNext;
  logic  flushPendingReg, flushPendingNext;
  logic  loadUseHazard;

  // A load into $zero never produces a real dependency.
  assign loadUseHazard = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
                         ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                          (ID_EX_RegisterRt == IF_ID_RegisterRt));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stateReg        <= RUN;
      flushPendingReg <= 1'b0;
    end else begin
      stateReg        <= stateNext;
      flushPendingReg <= flushPendingNext;
    end
  end

  always_comb begin
    pc_write_o       = 1'b1;
    if_id_write_o    = 1'b1;
    id_ex_bubble_o   = 1'b0;
    if_id_flush_o    = 1'b0;
    pipe_freeze_o    = 1'b0;
    stateNext        = stateReg;
    flushPendingNext = flushPendingReg;

    // The state only tracks the miss level. The exit cycle is the first cycle
    // with the stall low, and it is handled by the normal priority rules.
    if (dcache_stall_i) begin
      stateNext = MISS;
    end else begin
      stateNext = RUN;
    end

    if (dcache_stall_i) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      pipe_freeze_o = 1'b1;
      // The fetch side is frozen, so a flush now would be lost. Latch it and
      // apply it when the pipeline moves again.
      if (branch_taken_i) begin
        flushPendingNext = 1'b1;
      end
    end else if (loadUseHazard) begin
      // A bubble holds IF/ID. The branch in ID is re-resolved next cycle, and
      // any deferred flush waits for a cycle without a hazard.
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      id_ex_bubble_o = 1'b1;
    end else begin
      if_id_flush_o    = branch_taken_i || flushPendingReg;
      flushPendingNext = 1'b0;
    end

    // While reset is held, every control output is forced low.
    if (rst_i) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      id_ex_bubble_o = 1'b0;
      if_id_flush_o  = 1'b0;
      pipe_freeze_o  = 1'b0;
    end
  end

  assign state_o = stateReg;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] loadUseCntReg;
  logic [CNT_W-1:0] missCntReg;

  // Both counters saturate at all-ones. Only reset clears them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      loadUseCntReg <= '0;
      missCntReg    <= '0;
    end else begin
      if (id_ex_bubble_o && (loadUseCntReg != {CNT_W{1'b1}})) begin
        loadUseCntReg <= loadUseCntReg + 1'b1;
      end
      if ((stateReg == RUN) && dcache_stall_i && (missCntReg != {CNT_W{1'b1}})) begin
        missCntReg <= missCntReg + 1'b1;
      end
    end
  end

  assign loaduse_cnt_o = loadUseCntReg;
  assign miss_cnt_o    = missCntReg;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_unit
//
// Directed testbench for hazard_stall_unit. Inputs change 1 ns after each
// rising edge. Outputs are sampled on the following falling edge.
// The output vector checked at each step is packed as
//   {pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_freeze}.
// -----------------------------------------------------------------------------
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       memRead;
  logic [4:0] exRt;
  logic [4:0] idRs;
  logic [4:0] idRt;
  logic       branch;
  logic       stall;
  logic       pcWrite;
  logic       ifIdWrite;
  logic       bubble;
  logic       flush;
  logic       freeze;
  logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] loadUseCnt;
  logic [15:0] missCnt;
`endif

  int testCnt = 0;
  int failCnt = 0;

  always #5 clk = ~clk;

  hazard_stall_unit dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .ID_EX_MemRead    (memRead),
    .ID_EX_RegisterRt (exRt),
    .IF_ID_RegisterRs (idRs),
    .IF_ID_RegisterRt (idRt),
    .branch_taken_i   (branch),
    .dcache_stall_i   (stall),
    .pc_write_o       (pcWrite),
    .if_id_write_o    (ifIdWrite),
    .id_ex_bubble_o   (bubble),
    .if_id_flush_o    (flush),
    .pipe_freeze_o    (freeze),
    .state_o          (state)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .loaduse_cnt_o    (loadUseCnt),
    .miss_cnt_o       (missCnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    testCnt++;
    assert (obs === expv) else begin
      failCnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chkOut(input string tag, input logic [4:0] expv);
    chk(tag, {27'd0, pcWrite, ifIdWrite, bubble, flush, freeze}, {27'd0, expv});
  endtask

  task automatic chkState(input string tag, input logic [1:0] expv);
    chk(tag, {30'd0, state}, {30'd0, expv});
  endtask

  // Move to 1 ns after the next rising edge, where inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setIn(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                       input logic [4:0] rt, input logic br, input logic st);
    memRead = mr;
    exRt    = ert;
    idRs    = rs;
    idRt    = rt;
    branch  = br;
    stall   = st;
  endtask

  initial begin
    // Reset forces all outputs low, even with hostile inputs.
    rst = 1'b1;
    setIn(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b1);
    #4;
    chkOut("reset_outs", 5'b00000);
    chkState("reset_state", 2'b00);
    cyc();
    #4;
    chkOut("reset_outs_edge", 5'b00000);
    chkState("reset_state_edge", 2'b00);
`ifdef HAZARD_PERF_CNT_EN
    chk("reset_luCnt", {16'd0, loadUseCnt}, 32'd0);
    chk("reset_missCnt", {16'd0, missCnt}, 32'd0);
`endif

    cyc();
    rst = 1'b0;
    setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #4;
    chkOut("idle", 5'b11000);

    // Load-use on rs lasts one cycle. The load then moves on.
    cyc();
    setIn(1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0);
    #4;
    chkOut("luh_rs", 5'b00100);
    cyc();
    setIn(1'b0, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0);
    #4;
    chkOut("luh_rs_after", 5'b11000);
`ifdef HAZARD_PERF_CNT_EN
    chk("luCnt_one", {16'd0, loadUseCnt}, 32'd1);
`endif

    // Load-use on rt.
    cyc();
    setIn(1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0);
    #4;
    chkOut("luh_rt", 5'b00100);

    // A load into $zero never stalls.
    cyc();
    setIn(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #4;
    chkOut("zero_exempt", 5'b11000);

    // No match, so there is no stall.
    cyc();
    setIn(1'b1, 5'd8, 5'd9, 5'd10, 1'b0, 1'b0);
    #4;
    chkOut("no_match", 5'b11000);

    // A taken branch alone flushes IF/ID.
    cyc();
    setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    #4;
    chkOut("branch", 5'b11010);

    // 10-cycle miss: freeze for all 10 cycles, MISS state from cycle 2.
    for (int i = 1; i <= 10; i++) begin
      cyc();
      setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      #4;
      chkOut($sformatf("miss10_c%0d", i), 5'b00001);
      chkState($sformatf("miss10_st%0d", i), (i == 1) ? 2'b00 : 2'b01);
    end
    cyc();
    setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #4;
    chkOut("miss10_exit", 5'b11000);
`ifdef HAZARD_PERF_CNT_EN
    chk("missCnt_one", {16'd0, missCnt}, 32'd1);
`endif
    cyc();
    #4;
    chkState("miss10_back_run", 2'b00);
    chkOut("miss10_after", 5'b11000);

    // 6-cycle miss with a branch on cycle 3. The flush appears only on the
    // exit cycle.
    for (int i = 1; i <= 6; i++) begin
      cyc();
      setIn(1'b0, 5'd0, 5'd0, 5'd0, (i == 3), 1'b1);
      #4;
      chkOut($sformatf("defer_c%0d", i), 5'b00001);
    end
    cyc();
    setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #4;
    chkOut("defer_exit", 5'b11010);
    cyc();
    #4;
    chkOut("defer_cleared", 5'b11000);

    // Stall, luh and branch together: only the freeze is active. The branch
    // is remembered. The exit cycle has luh, so the bubble comes first and
    // the flush follows on the next clean cycle.
    cyc();
    setIn(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b1);
    #4;
    chkOut("prio_all", 5'b00001);
    cyc();
    setIn(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0);
    #4;
    chkOut("prio_exit_luh", 5'b00100);
    cyc();
    setIn(1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0);
    #4;
    chkOut("prio_late_flush", 5'b11010);
    cyc();
    #4;
    chkOut("prio_flush_once", 5'b11000);

    // Reset on the 4th cycle of a miss that has a pending flush.
    for (int i = 1; i <= 3; i++) begin
      cyc();
      setIn(1'b0, 5'd0, 5'd0, 5'd0, (i == 2), 1'b1);
      #4;
      chkOut($sformatf("rstmiss_c%0d", i), 5'b00001);
    end
    cyc();
    rst = 1'b1;
    #1;
    chkState("rstmiss_state", 2'b00);
    chkOut("rstmiss_outs", 5'b00000);
`ifdef HAZARD_PERF_CNT_EN
    chk("rstmiss_luCnt", {16'd0, loadUseCnt}, 32'd0);
    chk("rstmiss_missCnt", {16'd0, missCnt}, 32'd0);
`endif
    cyc();
    rst = 1'b0;
    setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #4;
    chkOut("rstmiss_no_flush", 5'b11000);
    cyc();
    #4;
    chkOut("rstmiss_no_flush2", 5'b11000);
    chkState("rstmiss_run", 2'b00);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
